// File: rtl/multiplier_seq_hs.sv
// multiplier_seq_hs
//   Multi-cycle WIDTH x WIDTH multiplier. Retires DIGIT bits of B per BUSY
//   cycle with shift-add accumulation, giving a 2*WIDTH-bit registered product
//   N = WIDTH/DIGIT edges after the operands are accepted.
//   Optional feature macro: MULT_SIGNED_EN (adds signed_mode, two's complement).
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   signed_mode  (MULT_SIGNED_EN only) operands are two's complement
//   in_valid     A/B valid            in_ready   block is IDLE, accepts operands
//   A, B         multiplicand / multiplier (WIDTH bits)
//   out_valid    product valid (DONE) out_ready  consumer takes the product
//   product      A*B, 2*WIDTH bits, registered
//   busy         high in BUSY or DONE
module multiplier_seq_hs #(
  parameter int unsigned WIDTH = 256,
  parameter int unsigned DIGIT = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
`ifdef MULT_SIGNED_EN
  input  logic                 signed_mode,
`endif
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy
);

  localparam int unsigned DSAFE = (DIGIT < 1) ? 1 : DIGIT;
  localparam int unsigned N     = WIDTH / DSAFE;
  localparam int unsigned CW    = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned PW    = 2 * WIDTH;

  if ((DIGIT < 1) || (WIDTH % DSAFE != 0)) begin : g_bad_param
    $error("multiplier_seq_hs: DIGIT must be >= 1 and divide WIDTH");
  end

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_nx;

  logic [PW-1:0]    a_sh;   // latched A, pre-shifted to the weight of the current digit
  logic [WIDTH-1:0] b_sh;   // latched B, current digit always in the low DIGIT bits
  logic [PW-1:0]    acc;
  logic [CW-1:0]    cnt;
  logic [PW-1:0]    sum;
  logic [PW-1:0]    result;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic             last;
  logic             accept;

`ifdef MULT_SIGNED_EN
  logic neg;
  // |-2^(WIDTH-1)| wraps to 2^(WIDTH-1), which is correct read as unsigned.
  assign mag_a  = (signed_mode && A[WIDTH-1]) ? (~A + WIDTH'(1)) : A;
  assign mag_b  = (signed_mode && B[WIDTH-1]) ? (~B + WIDTH'(1)) : B;
  assign result = neg ? (~sum + PW'(1)) : sum;
`else
  assign mag_a  = A;
  assign mag_b  = B;
  assign result = sum;
`endif

  // Shifting a_sh/b_sh by DIGIT each cycle is equivalent to indexing
  // B[cnt*DIGIT +: DIGIT] and shifting the partial product by cnt*DIGIT.
  assign sum    = acc + a_sh * PW'(b_sh[DIGIT-1:0]);
  assign last   = (cnt == CW'(N - 1));
  assign accept = (state == IDLE) && in_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_nx = BUSY;
      end
      BUSY: if (last) state_nx = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh    <= '0;
      b_sh    <= '0;
      acc     <= '0;
      cnt     <= '0;
      product <= '0;
`ifdef MULT_SIGNED_EN
      neg     <= 1'b0;
`endif
    end else if (accept) begin
      a_sh <= PW'(mag_a);
      b_sh <= mag_b;
      acc  <= '0;
      cnt  <= '0;
`ifdef MULT_SIGNED_EN
      neg  <= signed_mode && (A[WIDTH-1] ^ B[WIDTH-1]);
`endif
    end else if (state == BUSY) begin
      if (last) begin
        product <= result;
      end else begin
        acc  <= sum;
        a_sh <= a_sh << DIGIT;
        b_sh <= b_sh >> DIGIT;
        cnt  <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_multiplier_seq_hs.sv
module tb_multiplier_seq_hs;

  localparam int unsigned W = 256;
  localparam int unsigned D = 16;
  localparam int unsigned N = W / D;
  localparam int unsigned P = 2 * W;
`ifdef MULT_SIGNED_EN
  localparam bit SGN = 1'b1;
`else
  localparam bit SGN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic         signed_mode = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         in_ready, out_valid, busy;
  logic [P-1:0] product;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  multiplier_seq_hs #(.WIDTH(W), .DIGIT(D)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef MULT_SIGNED_EN
    .signed_mode(signed_mode),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (a),
    .B         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [P-1:0] got, input logic [P-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [P-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic s);
    logic signed [P-1:0] sx, sy;
    logic [P-1:0] ux, uy;
    if (s) begin
      sx = $signed(x);
      sy = $signed(y);
      return sx * sy;
    end
    ux = {{W{1'b0}}, x};
    uy = {{W{1'b0}}, y};
    return ux * uy;
  endfunction

  function automatic logic [W-1:0] rnd_w();
    logic [W-1:0] r;
    for (int unsigned i = 0; i < W / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // One full transaction: accept, latency, optional DONE hold, release.
  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                        input int unsigned hold, input string tag);
    logic [P-1:0] exp;
    int unsigned  edges;
    @(posedge clk); #1;
    chk({tag, ".in_ready_idle"}, P'(in_ready), P'(1));
    a = x; b = y; signed_mode = s; in_valid = 1'b1; out_ready = (hold == 0);
    exp = ref_mul(x, y, signed_mode);
    @(posedge clk); #1;
    edges = 1;
    in_valid = 1'b0;
    a = rnd_w(); b = rnd_w(); signed_mode = SGN & $urandom_range(0, 1);
    while (!out_valid && edges < 4 * N) begin
      @(posedge clk); #1;
      edges++;
    end
    chk({tag, ".latency"}, P'(edges - 1), P'(N));
    chk({tag, ".product"}, product, exp);
    chk({tag, ".in_ready_done"}, P'(in_ready), P'(0));
    chk({tag, ".busy_done"}, P'(busy), P'(1));
    for (int unsigned k = 0; k < hold; k++) begin
      in_valid = 1'b1;
      a = rnd_w(); b = rnd_w();
      @(posedge clk); #1;
      chk({tag, ".hold_valid"}, P'(out_valid), P'(1));
      chk({tag, ".hold_product"}, product, exp);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    if (hold != 0) begin
      @(posedge clk); #1;
    end else begin
      @(posedge clk); #1;
    end
    chk({tag, ".released_valid"}, P'(out_valid), P'(0));
    chk({tag, ".released_ready"}, P'(in_ready), P'(1));
    chk({tag, ".kept_product"}, product, exp);
    out_ready = 1'b0;
    @(posedge clk); #1;
    chk({tag, ".single_transfer"}, P'({busy, out_valid}), P'(0));
  endtask

  initial begin
    logic [W-1:0] ones, m3, mn;
    logic [P-1:0] ones_exp;
    ones = '1;
    m3 = '0; m3 = m3 - W'(3);
    mn = '0; mn[W-1] = 1'b1;

    #12;
    chk("rst.in_ready", P'(in_ready), P'(1));
    chk("rst.out_valid", P'(out_valid), P'(0));
    chk("rst.busy", P'(busy), P'(0));
    chk("rst.product", product, '0);
    @(negedge clk); rst_n = 1'b1;

    run_op(W'(3), W'(5), 1'b0, 0, "small");
    chk("small.value", product, P'(15));

    run_op(ones, ones, 1'b0, 0, "ones");
    ones_exp = '0;
    ones_exp = ones_exp - (P'(1) << (W + 1)) + P'(1);
    chk("ones.formula", product, ones_exp);

    run_op(W'(64'h5829EC10), W'(64'h123BBBCF00000000), 1'b0, 10, "bp");
    run_op('0, rnd_w(), 1'b0, 1, "zero_a");
    run_op(rnd_w(), '0, 1'b0, 0, "zero_b");

    for (int unsigned i = 0; i < 20; i++)
      run_op(rnd_w(), rnd_w(), SGN & $urandom_range(0, 1), $urandom_range(0, 3), "rand");

`ifdef MULT_SIGNED_EN
    run_op(m3, W'(5), 1'b1, 0, "s_neg");
    chk("s_neg.value", product, P'(0) - P'(15));
    run_op(mn, mn, 1'b1, 2, "s_min");
    chk("s_min.value", product, P'(1) << (P - 2));
    run_op(m3, m3, 1'b1, 0, "s_pos");
`endif

    // Abort in the middle of BUSY: product from the previous op must be cleared.
    @(posedge clk); #1;
    a = rnd_w(); b = rnd_w(); in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort.in_ready", P'(in_ready), P'(1));
    chk("abort.out_valid", P'(out_valid), P'(0));
    chk("abort.busy", P'(busy), P'(0));
    chk("abort.product", product, '0);
    @(negedge clk); rst_n = 1'b1;
    run_op(W'(2), W'(9), 1'b0, 0, "after_abort");
    chk("after_abort.value", product, P'(18));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
